// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of a single-port data memory.
// Byte-enable stores are performed as a read-modify-write; outputs are registered.
module dmem_arbiter #(
  parameter int unsigned DEPTH_WORDS = 32'd1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req0,
  input  logic        i_req1,
  input  logic        i_we0,
  input  logic        i_we1,
  input  logic [31:0] i_addr0,
  input  logic [31:0] i_addr1,
  input  logic [31:0] i_wdata0,
  input  logic [31:0] i_wdata1,
  input  logic [3:0]  i_be0,
  input  logic [3:0]  i_be1,
  output logic [31:0] o_rdata0,
  output logic [31:0] o_rdata1,
  output logic        o_ack0,
  output logic        o_ack1,
  output logic        o_err0,
  output logic        o_err1,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ACCESS = 3'd1;
  localparam logic [2:0] ST_RMW_RD = 3'd2;
  localparam logic [2:0] ST_RMW_WR = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [33:0] LP_LIMIT = 34'(DEPTH_WORDS) << 2;

  function automatic logic [31:0] f_merge(input logic [31:0] old_word,
                                          input logic [31:0] new_word,
                                          input logic [3:0]  be);
    logic [31:0] res;
    res = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return res;
  endfunction

  logic [2:0]  r_state;
  logic        r_last_grant;
  logic        r_gnt;
  logic        r_we;
  logic [31:2] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_ack0, r_ack1, r_err0, r_err1;
  logic [31:0] r_rdata0, r_rdata1;
  logic        r_mem_read, r_mem_write;
  logic [31:0] r_mem_addr, r_mem_wdata;

  logic        w_any, w_sel, w_in_we, w_in_err;
  logic [31:0] w_in_addr, w_in_wdata;
  logic [3:0]  w_in_be;

  logic [2:0]  w_state_nxt;
  logic        w_last_grant_nxt, w_gnt_nxt, w_we_nxt;
  logic [31:2] w_addr_nxt;
  logic [31:0] w_wdata_nxt;
  logic [3:0]  w_be_nxt;
  logic        w_ack_nxt, w_err_nxt, w_mem_read_nxt, w_mem_write_nxt;
  logic [31:0] w_rdata_nxt, w_mem_addr_nxt, w_mem_wdata_nxt;

  assign w_any      = i_req0 | i_req1;
  assign w_in_we    = w_sel ? i_we1    : i_we0;
  assign w_in_addr  = w_sel ? i_addr1  : i_addr0;
  assign w_in_wdata = w_sel ? i_wdata1 : i_wdata0;
  assign w_in_be    = w_sel ? i_be1    : i_be0;
  assign w_in_err   = (w_in_addr[1:0] != 2'b00) || ({2'b00, w_in_addr} >= LP_LIMIT);

  // Round-robin port selection: contention goes to the port not served last.
  always_comb begin
    w_sel = 1'b0;
    if (i_req0 && i_req1) begin
      w_sel = ~r_last_grant;
    end else if (i_req1) begin
      w_sel = 1'b1;
    end else begin
      w_sel = 1'b0;
    end
  end

  // Next-state and next-output decode; outputs are computed one cycle ahead.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_gnt_nxt        = r_gnt;
    w_we_nxt         = r_we;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_be_nxt         = r_be;
    w_ack_nxt        = 1'b0;
    w_err_nxt        = 1'b0;
    w_rdata_nxt      = 32'h0000_0000;
    w_mem_read_nxt   = 1'b0;
    w_mem_write_nxt  = 1'b0;
    w_mem_addr_nxt   = 32'h0000_0000;
    w_mem_wdata_nxt  = 32'h0000_0000;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_last_grant_nxt = w_sel;
          w_gnt_nxt        = w_sel;
          w_we_nxt         = w_in_we;
          w_addr_nxt       = w_in_addr[31:2];
          w_wdata_nxt      = w_in_wdata;
          w_be_nxt         = w_in_be;
          if (w_in_err) begin
            w_state_nxt = ST_DONE;
            w_ack_nxt   = 1'b1;
            w_err_nxt   = 1'b1;
          end else if (w_in_we && (w_in_be == 4'h0)) begin
            w_state_nxt = ST_DONE;
            w_ack_nxt   = 1'b1;
          end else if (!w_in_we || (w_in_be == 4'hF)) begin
            w_state_nxt     = ST_ACCESS;
            w_mem_read_nxt  = ~w_in_we;
            w_mem_write_nxt = w_in_we;
            w_mem_addr_nxt  = {w_in_addr[31:2], 2'b00};
            w_mem_wdata_nxt = w_in_we ? w_in_wdata : 32'h0000_0000;
          end else begin
            w_state_nxt    = ST_RMW_RD;
            w_mem_read_nxt = 1'b1;
            w_mem_addr_nxt = {w_in_addr[31:2], 2'b00};
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        w_state_nxt = ST_DONE;
        w_ack_nxt   = 1'b1;
        w_rdata_nxt = r_we ? 32'h0000_0000 : i_mem_rdata;
      end
      ST_RMW_RD: begin
        // Old word is merged straight into the registered write data.
        w_state_nxt     = ST_RMW_WR;
        w_mem_write_nxt = 1'b1;
        w_mem_addr_nxt  = {r_addr, 2'b00};
        w_mem_wdata_nxt = f_merge(i_mem_rdata, r_wdata, r_be);
      end
      ST_RMW_WR: begin
        w_state_nxt = ST_DONE;
        w_ack_nxt   = 1'b1;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, request capture and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_gnt        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= 30'h0000_0000;
      r_wdata      <= 32'h0000_0000;
      r_be         <= 4'h0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_err0       <= 1'b0;
      r_err1       <= 1'b0;
      r_rdata0     <= 32'h0000_0000;
      r_rdata1     <= 32'h0000_0000;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= 32'h0000_0000;
      r_mem_wdata  <= 32'h0000_0000;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_gnt        <= w_gnt_nxt;
      r_we         <= w_we_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_be         <= w_be_nxt;
      r_ack0       <= w_ack_nxt & ~w_gnt_nxt;
      r_ack1       <= w_ack_nxt &  w_gnt_nxt;
      r_err0       <= w_err_nxt & ~w_gnt_nxt;
      r_err1       <= w_err_nxt &  w_gnt_nxt;
      r_rdata0     <= w_gnt_nxt ? 32'h0000_0000 : w_rdata_nxt;
      r_rdata1     <= w_gnt_nxt ? w_rdata_nxt : 32'h0000_0000;
      r_mem_read   <= w_mem_read_nxt;
      r_mem_write  <= w_mem_write_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
    end
  end

  assign o_ack0      = r_ack0;
  assign o_ack1      = r_ack1;
  assign o_err0      = r_err0;
  assign o_err1      = r_err1;
  assign o_rdata0    = r_rdata0;
  assign o_rdata1    = r_rdata1;
  assign o_mem_read  = r_mem_read;
  // Gated so a reset landing on a write cycle never commits the word.
  assign o_mem_write = r_mem_write & ~i_rst;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural memory and a scoreboard of
// expected completions (port, read data, error) checked when an ack appears.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = 32'h0, addr1 = 32'h0, wdata0 = 32'h0, wdata1 = 32'h0;
  logic [3:0]  be0 = 4'h0, be1 = 4'h0;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  logic        ack0, ack1, err0, err1, mem_read, mem_write;

  logic [31:0] mem [0:1023];
  logic        pre_en = 1'b0;
  logic [9:0]  pre_idx = 10'd0;
  logic [31:0] pre_val = 32'h0;

  typedef struct packed {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.DEPTH_WORDS(1024)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
    .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
    .i_be0(be0), .i_be1(be1),
    .o_rdata0(rdata0), .o_rdata1(rdata1), .o_ack0(ack0), .o_ack1(ack1),
    .o_err0(err0), .o_err1(err1), .o_mem_read(mem_read), .o_mem_write(mem_write),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[11:2]];

  // Memory writes on the falling edge; preloads share the same process.
  always @(negedge clk) begin
    if (mem_write) mem[mem_addr[11:2]] <= mem_wdata;
    else if (pre_en) mem[pre_idx] <= pre_val;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] val);
    pre_idx = idx; pre_val = val; pre_en = 1'b1;
    @(negedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic check_ack(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_port"}, {62'd0, ack1, ack0}, e.port ? 64'd2 : 64'd1);
      chk({tag, "_rdata"}, e.port ? rdata1 : rdata0, e.rdata);
      chk({tag, "_other_rdata"}, e.port ? rdata0 : rdata1, 64'd0);
      chk({tag, "_err"}, {62'd0, err1, err0}, e.err ? (e.port ? 64'd2 : 64'd1) : 64'd0);
    end
  endtask

  // Issue one request, then check latency, memory pin activity and completion.
  task automatic do_req(input string tag, input logic p, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be, input int lat,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input logic [7:0] rmask, input logic [7:0] wmask, input logic [31:0] exp_wd);
    int n;
    logic [7:0] rseen, wseen;
    logic [31:0] wdseen;
    @(posedge clk); #1;
    if (p) begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; be1 = be; end
    else begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd; be0 = be; end
    sb.push_back('{p, exp_rd, exp_err});
    n = 0; rseen = 8'h00; wseen = 8'h00; wdseen = 32'h0;
    while (n < 7) begin
      @(posedge clk); #2;
      n++;
      rseen[n] = mem_read;
      wseen[n] = mem_write;
      if (mem_read || mem_write) chk({tag, "_mem_addr"}, mem_addr, {addr[31:2], 2'b00});
      if (mem_write) wdseen = mem_wdata;
      if (ack0 || ack1) break;
    end
    chk({tag, "_latency"}, n, lat);
    check_ack(tag);
    chk({tag, "_rd_cycles"}, rseen, rmask);
    chk({tag, "_wr_cycles"}, wseen, wmask);
    if (wmask != 8'h00) chk({tag, "_mem_wdata"}, wdseen, exp_wd);
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #2;
    chk({tag, "_ack_width"}, {62'd0, ack0, ack1}, 64'd0);
  endtask

  initial begin
    int n, k;
    logic prev_ack;
    int ack1_seen;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ctrl", {58'd0, ack0, ack1, err0, err1, mem_read, mem_write}, 64'd0);
    chk("rst_rdata", {rdata0, rdata1}, 64'd0);
    chk("rst_mem", {mem_addr, mem_wdata}, 64'd0);
    preload(10'h010, 32'hAABB_CCDD);
    preload(10'h3FF, 32'hCAFE_F00D);
    @(posedge clk); #1;
    rst = 1'b0;

    do_req("rd40", 1'b0, 1'b0, 32'h40, 32'h0, 4'h0, 2, 32'hAABB_CCDD, 1'b0, 8'h02, 8'h00, 32'h0);
    do_req("wr44", 1'b1, 1'b1, 32'h44, 32'h1234_5678, 4'hF, 2, 32'h0, 1'b0, 8'h00, 8'h02, 32'h1234_5678);
    do_req("rd44", 1'b0, 1'b0, 32'h44, 32'h0, 4'h0, 2, 32'h1234_5678, 1'b0, 8'h02, 8'h00, 32'h0);
    do_req("rmw40", 1'b0, 1'b1, 32'h40, 32'h1122_3344, 4'b0101, 3, 32'h0, 1'b0, 8'h02, 8'h04, 32'hAA22_CC44);
    do_req("rd40b", 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 2, 32'hAA22_CC44, 1'b0, 8'h02, 8'h00, 32'h0);
    do_req("mis42", 1'b0, 1'b0, 32'h42, 32'h0, 4'h0, 1, 32'h0, 1'b1, 8'h00, 8'h00, 32'h0);
    do_req("oob1000", 1'b0, 1'b1, 32'h1000, 32'hDEAD_BEEF, 4'hF, 1, 32'h0, 1'b1, 8'h00, 8'h00, 32'h0);
    do_req("be0", 1'b1, 1'b1, 32'h44, 32'hFFFF_FFFF, 4'h0, 1, 32'h0, 1'b0, 8'h00, 8'h00, 32'h0);
    do_req("rd44b", 1'b1, 1'b0, 32'h44, 32'h0, 4'h0, 2, 32'h1234_5678, 1'b0, 8'h02, 8'h00, 32'h0);
    do_req("rdFFC", 1'b1, 1'b0, 32'hFFC, 32'h0, 4'h0, 2, 32'hCAFE_F00D, 1'b0, 8'h02, 8'h00, 32'h0);

    // Both ports held from reset: grants alternate starting with port 0
    @(posedge clk); #1;
    rst = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h44;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.push_back('{1'b0, 32'hAA22_CC44, 1'b0});
    sb.push_back('{1'b1, 32'h1234_5678, 1'b0});
    sb.push_back('{1'b0, 32'hAA22_CC44, 1'b0});
    sb.push_back('{1'b1, 32'h1234_5678, 1'b0});
    k = 0; prev_ack = 1'b0;
    for (n = 1; n <= 12; n++) begin
      @(posedge clk); #2;
      if (ack0 || ack1) begin
        chk("rr_ack_gap", {63'd0, prev_ack}, 64'd0);
        chk("rr_cycle", n, 2 + 3 * k);
        check_ack("rr");
        k++;
      end
      prev_ack = ack0 | ack1;
    end
    chk("rr_count", k, 4);
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #2;

    // Reset lands in the RMW write cycle: nothing written, no ack
    @(posedge clk); #1;
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h44; wdata1 = 32'hFFFF_FFFF; be1 = 4'b0011;
    @(posedge clk); #2;
    chk("rstmid_rmw_rd", {63'd0, mem_read}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rstmid_wr_gated", {63'd0, mem_write}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; req1 = 1'b0;
    #1;
    chk("rstmid_ctrl", {58'd0, ack0, ack1, err0, err1, mem_read, mem_write}, 64'd0);
    chk("rstmid_data", {rdata0, rdata1}, 64'd0);
    ack1_seen = 0;
    repeat (4) begin
      @(posedge clk); #2;
      if (ack1) ack1_seen++;
    end
    chk("rstmid_no_ack", ack1_seen, 0);
    do_req("rd44c", 1'b0, 1'b0, 32'h44, 32'h0, 4'h0, 2, 32'h1234_5678, 1'b0, 8'h02, 8'h00, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
